ram_copier: RTL
===============

// Module: ram_copier
//
// PURPOSE
//   Initiator-side engine for the single-port RAM interface (addr/din/dout/write_en).
//   - Copies len words from a source region to a destination region of the same RAM:
//     one read cycle, then one write cycle, per word.
//   - Sits between the control core and the RAM; the core starts a block copy and waits for done.
//   - The RAM read path is combinational (dout follows addr in the same cycle); writes occur on posedge clk.
//
// PARAMETERS
//   WIDTH   16  data word width; must match the attached RAM
//   AWIDTH   8  RAM address width; the RAM depth is 2**AWIDTH
//
// PORTS
//   clk           in   1         clock; all state updates on posedge
//   rst_n         in   1         asynchronous reset, active-low
//   start         in   1         request a copy; sampled only in IDLE
//   src           in   AWIDTH    first source address; captured on accepted start
//   dst           in   AWIDTH    first destination address; captured on accepted start
//   len           in   AWIDTH+1  word count, 0..2**AWIDTH; captured on accepted start
//   busy          out  1         high from the cycle after an accepted start until DONE completes
//   done          out  1         one-cycle pulse when the copy finishes
//   ram_addr      out  AWIDTH    RAM address
//   ram_din       out  WIDTH     RAM write data
//   ram_write_en  out  1         RAM write strobe
//   ram_dout      in   WIDTH     RAM read data; combinational from ram_addr
//
// BEHAVIOUR
//   Reset (async, rst_n=0)
//   - state=IDLE; idx=0; data_q=0.
//   - busy=0, done=0, ram_write_en=0, ram_addr=0, ram_din=0.
//   - Reset asserted mid-copy: ram_write_en drops immediately and the FSM returns to IDLE.
//     Words already written stay written; no done pulse is issued.
//
//   FSM states: IDLE, RD, WR, DONE
//   - IDLE: when start=1, capture src/dst/len and set idx=0.
//     Go to RD if len!=0, otherwise go to DONE.
//   - RD: ram_addr = src_q+idx (mod 2**AWIDTH), ram_write_en=0.
//     data_q <= ram_dout at posedge; then go to WR.
//   - WR: ram_addr = dst_q+idx (mod 2**AWIDTH), ram_din=data_q, ram_write_en=1.
//     If idx+1 == len_q, go to DONE; otherwise idx <= idx+1 and go to RD.
//   - DONE: done=1 for exactly one cycle, then go to IDLE.
//
//   Outputs per state
//   - busy=1 in RD, WR and DONE; busy=0 in IDLE.
//   - In IDLE and DONE: ram_addr=0, ram_din=0, ram_write_en=0.
//   - Outputs are decoded from registered state and registers only; there is no combinational path from start.
//
//   Timing
//   - Start accepted at edge E0.
//   - Word k is read in cycle 2k+1 and written in cycle 2k+2 (cycles counted after E0).
//   - done is high in cycle 2*len+1; for len=0, done is high in cycle 1.
//   - A new start is accepted in the cycle after DONE at the earliest.
//
//   Boundary conditions
//   - start while busy: ignored; the captured operands are unchanged.
//   - Address arithmetic wraps modulo 2**AWIDTH for both regions.
//   - len=2**AWIDTH copies the whole RAM.
//   - Overlapping regions are copied strictly forward: word idx is read before word idx is written.
//     Consequence: with dst=src+1 the value at src is replicated across the region.
//     This behaviour is defined; there is no overlap detection.
//   - src==dst: every word is rewritten with its own value; the memory is unchanged.
//   - idx is AWIDTH+1 bits wide so that len=2**AWIDTH terminates correctly.
//
// TESTING (bench instantiates ram WIDTH=16 with ram_copier on one clk)
//   1. Preload mem[0..3]={A,B,C,D}; start src=0 dst=8 len=4
//      -> mem[8..11]={A,B,C,D}; done high in cycle 9 after start; busy low in cycle 10.
//   2. start len=0
//      -> done pulses in cycle 1; ram_write_en is never asserted; memory unchanged.
//   3. Preload mem[254]=X, mem[255]=Y, mem[0]=Z; start src=254 dst=16 len=3
//      -> mem[16..18]={X,Y,Z}, confirming address wrap.
//   4. Overlap: preload mem[0..3]={1,2,3,4}; start src=0 dst=1 len=3
//      -> mem[0..3]={1,1,1,1}.
//   5. Assert start again in the 2nd busy cycle with different operands
//      -> ignored; the original copy completes unchanged.
//   6. Pulse rst_n low during a WR cycle of a len=8 copy
//      -> ram_write_en=0 and busy=0 immediately; no done pulse; a later start works normally.

Source files
------------

// File: rtl/ram_copier.sv
// rtl/ram_copier.sv - block copy engine for a single-port RAM (one read, one write per word)
//
// Purpose
//   Copies i_len words from the region starting at i_src to the region starting
//   at i_dst of the attached RAM. Each word takes a read cycle (RD) followed by
//   a write cycle (WR). Address arithmetic wraps modulo 2**AWIDTH. Overlapping
//   regions are copied strictly forward.
//
// Ports
//   i_clk           clock, all state updates on the rising edge
//   i_rst_n         asynchronous reset, active-low
//   i_start         copy request, sampled only while idle
//   i_src           first source address, captured on an accepted start
//   i_dst           first destination address, captured on an accepted start
//   i_len           word count 0..2**AWIDTH, captured on an accepted start
//   o_busy          high in RD, WR and DONE
//   o_done          one-cycle pulse when the copy finishes
//   o_ram_addr      RAM address
//   o_ram_din       RAM write data
//   o_ram_write_en  RAM write strobe
//   i_ram_dout      RAM read data, combinational from o_ram_addr

module ram_copier #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [AWIDTH-1:0] i_src,
    input  logic [AWIDTH-1:0] i_dst,
    input  logic [AWIDTH:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [AWIDTH-1:0] o_ram_addr,
    output logic [WIDTH-1:0]  o_ram_din,
    output logic              o_ram_write_en,
    input  logic [WIDTH-1:0]  i_ram_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [AWIDTH-1:0] r_src_q;
    logic [AWIDTH-1:0] r_dst_q;
    logic [AWIDTH:0]   r_len_q;
    // One bit wider than an address so that a full-RAM copy (len = 2**AWIDTH)
    // can reach its terminal count.
    logic [AWIDTH:0]   r_idx;
    // Word fetched in RD; doubles as the write-data output register and is
    // cleared whenever no write is in progress.
    logic [WIDTH-1:0]  r_data_q;
    logic              r_busy;
    logic              r_done;
    logic [AWIDTH-1:0] r_ram_addr;
    logic              r_ram_write_en;

    logic [AWIDTH:0]   w_idx_inc;
    logic              w_last;
    logic [AWIDTH-1:0] w_wr_addr;
    logic [AWIDTH-1:0] w_next_rd_addr;

    assign w_idx_inc      = r_idx + {{AWIDTH{1'b0}}, 1'b1};
    assign w_last         = (w_idx_inc == r_len_q);
    // Both sums are AWIDTH bits wide, so the carry falls off and the regions wrap.
    assign w_wr_addr      = r_dst_q + r_idx[AWIDTH-1:0];
    assign w_next_rd_addr = r_src_q + w_idx_inc[AWIDTH-1:0];

    // Outputs are registered and loaded on the transition into each state, so
    // they are valid for the whole cycle the FSM spends in that state and never
    // depend combinationally on i_start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_src_q        <= '0;
            r_dst_q        <= '0;
            r_len_q        <= '0;
            r_idx          <= '0;
            r_data_q       <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_write_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done         <= 1'b0;
                    r_ram_write_en <= 1'b0;
                    r_data_q       <= '0;
                    r_ram_addr     <= '0;
                    if (i_start) begin
                        r_src_q <= i_src;
                        r_dst_q <= i_dst;
                        r_len_q <= i_len;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        if (i_len != '0) begin
                            r_state    <= S_RD;
                            r_ram_addr <= i_src;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    // The RAM read is combinational: the word at src+idx is on
                    // i_ram_dout now and is presented as write data in WR.
                    r_data_q       <= i_ram_dout;
                    r_ram_addr     <= w_wr_addr;
                    r_ram_write_en <= 1'b1;
                    r_state        <= S_WR;
                end

                S_WR: begin
                    r_ram_write_en <= 1'b0;
                    r_data_q       <= '0;
                    if (w_last) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_ram_addr <= '0;
                    end else begin
                        r_idx      <= w_idx_inc;
                        r_state    <= S_RD;
                        r_ram_addr <= w_next_rd_addr;
                    end
                end

                S_DONE: begin
                    r_done         <= 1'b0;
                    r_busy         <= 1'b0;
                    r_ram_addr     <= '0;
                    r_ram_write_en <= 1'b0;
                    r_data_q       <= '0;
                    r_state        <= S_IDLE;
                end

                default: begin
                    r_state        <= S_IDLE;
                    r_busy         <= 1'b0;
                    r_done         <= 1'b0;
                    r_ram_addr     <= '0;
                    r_ram_write_en <= 1'b0;
                    r_data_q       <= '0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_ram_addr     = r_ram_addr;
    assign o_ram_din      = r_data_q;
    assign o_ram_write_en = r_ram_write_en;

endmodule
